// File: rtl/axi_mesh_pkg.sv
// -----------------------------------------------------------------------------
// axi_mesh_pkg
// Definitions shared by the mesh write packetizer and the home-side write
// responder: packet-kind codes, the header / AW subheader / B subheader bit
// layouts expressed as field-offset functions, and the responder FSM states.
// Header layout, LSB-first:  tag[7:0], dest_x, dest_y, src_x, src_y
// AW subheader, LSB-first:   awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0]
// B subheader, LSB-first:    bid, bresp[1:0]
// -----------------------------------------------------------------------------
package axi_mesh_pkg;

  localparam logic [2:0] TID_WRITE_REQ  = 3'd0;
  localparam logic [2:0] TID_WRITE_RESP = 3'd2;

  localparam int TAG_WIDTH       = 8;
  localparam int AXI_LEN_WIDTH   = 8;
  localparam int AXI_SIZE_WIDTH  = 3;
  localparam int AXI_RESP_WIDTH  = 2;

  // A mesh dimension of one still needs a one-bit coordinate field.
  function automatic int coord_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int hdr_dest_x_lsb();
    return TAG_WIDTH;
  endfunction

  function automatic int hdr_dest_y_lsb(input int xw);
    return TAG_WIDTH + xw;
  endfunction

  function automatic int hdr_src_x_lsb(input int xw, input int yw);
    return TAG_WIDTH + xw + yw;
  endfunction

  function automatic int hdr_src_y_lsb(input int xw, input int yw);
    return TAG_WIDTH + 2 * xw + yw;
  endfunction

  function automatic int aw_addr_lsb(input int idw);
    return idw;
  endfunction

  function automatic int aw_len_lsb(input int idw, input int aw);
    return idw + aw;
  endfunction

  function automatic int aw_size_lsb(input int idw, input int aw);
    return idw + aw + AXI_LEN_WIDTH;
  endfunction

  function automatic int aw_burst_lsb(input int idw, input int aw);
    return idw + aw + AXI_LEN_WIDTH + AXI_SIZE_WIDTH;
  endfunction

  function automatic int b_sub_width(input int idw);
    return idw + AXI_RESP_WIDTH;
  endfunction

  typedef enum logic [2:0] {
    ST_HDR,
    ST_AWSUB,
    ST_AW,
    ST_WDATA,
    ST_BWAIT,
    ST_RHDR,
    ST_RSUB,
    ST_DRAIN
  } wr_state_t;

endpackage

// File: rtl/mesh_resp_packetizer.sv
// -----------------------------------------------------------------------------
// mesh_resp_packetizer
// Builds the two-flit B response packet sent back to the requester.
// Purely combinational: the caller keeps its inputs stable while a flit is
// offered, so the flit stays stable under backpressure.
// Ports:
//   send_hdr / send_sub   select which flit (if any) is presented
//   dest_x / dest_y       requester coordinates (destination of the response)
//   bid / bresp           captured AXI write response
//   m_resp_*              AXIS response flit outputs
// -----------------------------------------------------------------------------
module mesh_resp_packetizer
  import axi_mesh_pkg::*;
#(
  parameter int ID_W_WIDTH         = 5,
  parameter int AXIS_CHANNEL_WIDTH = 40,
  parameter int ROUTER_X           = 0,
  parameter int ROUTER_Y           = 0,
  parameter int MAX_ROUTERS_X      = 4,
  parameter int MAX_ROUTERS_Y      = 4
) (
  input  logic                                  send_hdr,
  input  logic                                  send_sub,
  input  logic [coord_width(MAX_ROUTERS_X)-1:0] dest_x,
  input  logic [coord_width(MAX_ROUTERS_Y)-1:0] dest_y,
  input  logic [ID_W_WIDTH-1:0]                 bid,
  input  logic [1:0]                            bresp,
  output logic                                  m_resp_tvalid,
  output logic                                  m_resp_tlast,
  output logic [AXIS_CHANNEL_WIDTH-1:0]         m_resp_tdata,
  output logic [2:0]                            m_resp_tid
);

  localparam int XW       = coord_width(MAX_ROUTERS_X);
  localparam int YW       = coord_width(MAX_ROUTERS_Y);
  localparam int DX_LSB   = hdr_dest_x_lsb();
  localparam int DY_LSB   = hdr_dest_y_lsb(XW);
  localparam int SX_LSB   = hdr_src_x_lsb(XW, YW);
  localparam int SY_LSB   = hdr_src_y_lsb(XW, YW);
  localparam int BSUB_W   = b_sub_width(ID_W_WIDTH);

  localparam logic [XW-1:0] OWN_X = XW'(ROUTER_X);
  localparam logic [YW-1:0] OWN_Y = YW'(ROUTER_Y);

  // Tag field and all unused high bits stay zero in both flits.
  always_comb begin
    m_resp_tvalid = 1'b0;
    m_resp_tlast  = 1'b0;
    m_resp_tid    = '0;
    m_resp_tdata  = '0;
    if (send_hdr) begin
      m_resp_tvalid                 = 1'b1;
      m_resp_tid                    = TID_WRITE_RESP;
      m_resp_tdata[DX_LSB +: XW]    = dest_x;
      m_resp_tdata[DY_LSB +: YW]    = dest_y;
      m_resp_tdata[SX_LSB +: XW]    = OWN_X;
      m_resp_tdata[SY_LSB +: YW]    = OWN_Y;
    end else if (send_sub) begin
      m_resp_tvalid                 = 1'b1;
      m_resp_tlast                  = 1'b1;
      m_resp_tid                    = TID_WRITE_RESP;
      m_resp_tdata[BSUB_W-1:0]      = {bresp, bid};
    end
  end

endmodule

// File: rtl/axis2axi_write_responder.sv
// -----------------------------------------------------------------------------
// axis2axi_write_responder
// Home-side receiver for mesh write-request packets. Decodes the routing
// header and AW subheader, replays the write on an AXI4 master (AW, then W
// beats streamed straight from the request flits), captures B and returns a
// B response packet to the requester. One transaction in flight at a time.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_req_*             AXIS request flits from the router HOME_REQ output
//   m_axi_aw*/w*/b*     AXI4 write master
//   m_resp_*            AXIS response flits to the HOME_RESP injection port
// -----------------------------------------------------------------------------
module axis2axi_write_responder
  import axi_mesh_pkg::*;
#(
  parameter int ADDR_WIDTH         = 16,
  parameter int DATA_WIDTH         = 8,
  parameter int ID_W_WIDTH         = 5,
  parameter int AXIS_CHANNEL_WIDTH = 40,
  parameter int ROUTER_X           = 0,
  parameter int ROUTER_Y           = 0,
  parameter int MAX_ROUTERS_X      = 4,
  parameter int MAX_ROUTERS_Y      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_req_tvalid,
  output logic                          s_req_tready,
  input  logic                          s_req_tlast,
  input  logic [AXIS_CHANNEL_WIDTH-1:0] s_req_tdata,
  input  logic [2:0]                    s_req_tid,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [ID_W_WIDTH-1:0]         m_axi_awid,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic                          m_axi_wlast,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [ID_W_WIDTH-1:0]         m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_resp_tvalid,
  input  logic                          m_resp_tready,
  output logic                          m_resp_tlast,
  output logic [AXIS_CHANNEL_WIDTH-1:0] m_resp_tdata,
  output logic [2:0]                    m_resp_tid
);

  localparam int XW        = coord_width(MAX_ROUTERS_X);
  localparam int YW        = coord_width(MAX_ROUTERS_Y);
  localparam int DX_LSB    = hdr_dest_x_lsb();
  localparam int DY_LSB    = hdr_dest_y_lsb(XW);
  localparam int SX_LSB    = hdr_src_x_lsb(XW, YW);
  localparam int SY_LSB    = hdr_src_y_lsb(XW, YW);
  localparam int ADDR_LSB  = aw_addr_lsb(ID_W_WIDTH);
  localparam int LEN_LSB   = aw_len_lsb(ID_W_WIDTH, ADDR_WIDTH);
  localparam int SIZE_LSB  = aw_size_lsb(ID_W_WIDTH, ADDR_WIDTH);
  localparam int BURST_LSB = aw_burst_lsb(ID_W_WIDTH, ADDR_WIDTH);

  localparam logic [XW-1:0] OWN_X = XW'(ROUTER_X);
  localparam logic [YW-1:0] OWN_Y = YW'(ROUTER_Y);

  wr_state_t state, state_next;

  logic [XW-1:0]         src_x_q;
  logic [YW-1:0]         src_y_q;
  logic [ID_W_WIDTH-1:0] awid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [2:0]            awsize_q;
  logic [1:0]            awburst_q;
  logic [7:0]            beat_cnt;
  logic [ID_W_WIDTH-1:0] bid_q;
  logic [1:0]            bresp_q;

  logic hdr_accept;
  logic send_hdr;
  logic send_sub;
  logic unused_tdata;

  // Different flits use different slices of tdata; the rest is don't-care.
  assign unused_tdata = ^s_req_tdata;

  // A header is only taken as a transaction if it is a write request for this
  // node and more flits follow; everything else is drained.
  assign hdr_accept = (s_req_tid == TID_WRITE_REQ)
                   && (s_req_tdata[DX_LSB +: XW] == OWN_X)
                   && (s_req_tdata[DY_LSB +: YW] == OWN_Y)
                   && !s_req_tlast;

  assign m_axi_awid    = awid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = awsize_q;
  assign m_axi_awburst = awburst_q;
  assign m_axi_wdata   = s_req_tdata[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HDR;
    end else begin
      state <= state_next;
    end
  end

  // In WDATA the request stream is wired straight onto the W channel, so a
  // handshake on one side is a handshake on the other. The beat count comes
  // from awlen alone; the request tlast is not trusted on data flits.
  always_comb begin
    state_next    = state;
    s_req_tready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    send_hdr      = 1'b0;
    send_sub      = 1'b0;
    case (state)
      ST_HDR: begin
        s_req_tready = 1'b1;
        if (s_req_tvalid) begin
          if (hdr_accept) begin
            state_next = ST_AWSUB;
          end else if (!s_req_tlast) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_AWSUB: begin
        s_req_tready = 1'b1;
        if (s_req_tvalid) begin
          state_next = s_req_tlast ? ST_HDR : ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          state_next = ST_WDATA;
        end
      end
      ST_WDATA: begin
        m_axi_wvalid = s_req_tvalid;
        s_req_tready = m_axi_wready;
        m_axi_wlast  = (beat_cnt == awlen_q);
        if (s_req_tvalid && m_axi_wready && (beat_cnt == awlen_q)) begin
          state_next = ST_BWAIT;
        end
      end
      ST_BWAIT: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_next = ST_RHDR;
        end
      end
      ST_RHDR: begin
        send_hdr = 1'b1;
        if (m_resp_tready) begin
          state_next = ST_RSUB;
        end
      end
      ST_RSUB: begin
        send_sub = 1'b1;
        if (m_resp_tready) begin
          state_next = ST_HDR;
        end
      end
      ST_DRAIN: begin
        s_req_tready = 1'b1;
        if (s_req_tvalid && s_req_tlast) begin
          state_next = ST_HDR;
        end
      end
      default: begin
        state_next = ST_HDR;
      end
    endcase
    if (rst) begin
      s_req_tready = 1'b0;
    end
  end

  // Transaction context captured along the way; held untouched while the
  // AW request and response flits are offered so they cannot change under
  // backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_x_q   <= '0;
      src_y_q   <= '0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      beat_cnt  <= '0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (state)
        ST_HDR: begin
          if (s_req_tvalid && hdr_accept) begin
            src_x_q <= s_req_tdata[SX_LSB +: XW];
            src_y_q <= s_req_tdata[SY_LSB +: YW];
          end
        end
        ST_AWSUB: begin
          if (s_req_tvalid) begin
            awid_q    <= s_req_tdata[0 +: ID_W_WIDTH];
            awaddr_q  <= s_req_tdata[ADDR_LSB +: ADDR_WIDTH];
            awlen_q   <= s_req_tdata[LEN_LSB +: 8];
            awsize_q  <= s_req_tdata[SIZE_LSB +: 3];
            awburst_q <= s_req_tdata[BURST_LSB +: 2];
            beat_cnt  <= '0;
          end
        end
        ST_WDATA: begin
          if (s_req_tvalid && m_axi_wready) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        ST_BWAIT: begin
          if (m_axi_bvalid) begin
            bid_q   <= m_axi_bid;
            bresp_q <= m_axi_bresp;
          end
        end
        default: begin
        end
      endcase
    end
  end

  mesh_resp_packetizer #(
    .ID_W_WIDTH         (ID_W_WIDTH),
    .AXIS_CHANNEL_WIDTH (AXIS_CHANNEL_WIDTH),
    .ROUTER_X           (ROUTER_X),
    .ROUTER_Y           (ROUTER_Y),
    .MAX_ROUTERS_X      (MAX_ROUTERS_X),
    .MAX_ROUTERS_Y      (MAX_ROUTERS_Y)
  ) u_resp_packetizer (
    .send_hdr      (send_hdr),
    .send_sub      (send_sub),
    .dest_x        (src_x_q),
    .dest_y        (src_y_q),
    .bid           (bid_q),
    .bresp         (bresp_q),
    .m_resp_tvalid (m_resp_tvalid),
    .m_resp_tlast  (m_resp_tlast),
    .m_resp_tdata  (m_resp_tdata),
    .m_resp_tid    (m_resp_tid)
  );

endmodule
